// File: rtl/pool_frame_arbiter_if.sv
// Bundle between the two conv requesters, the frame arbiter and the shared maxpool.
// master = requester/pool side, slave = arbiter.
interface pool_frame_arbiter_if #(
   parameter int CONV_BIT = 12
);
   logic                  req_a;
   logic                  req_b;
   logic                  valid_a;
   logic                  valid_b;
   logic [3*CONV_BIT-1:0] data_a;
   logic [3*CONV_BIT-1:0] data_b;
   logic                  gnt_a;
   logic                  gnt_b;
   logic                  pool_clr_n;
   logic                  pool_valid_in;
   logic [CONV_BIT-1:0]   pool_conv_out_1;
   logic [CONV_BIT-1:0]   pool_conv_out_2;
   logic [CONV_BIT-1:0]   pool_conv_out_3;
   logic                  pool_valid_out;
   logic                  owner;
   logic                  busy;
   logic                  done_a;
   logic                  done_b;
   logic                  err_overrun;

   modport master (
      output req_a, req_b, valid_a, valid_b, data_a, data_b, pool_valid_out,
      input  gnt_a, gnt_b, pool_clr_n, pool_valid_in,
      input  pool_conv_out_1, pool_conv_out_2, pool_conv_out_3,
      input  owner, busy, done_a, done_b, err_overrun
   );

   modport slave (
      input  req_a, req_b, valid_a, valid_b, data_a, data_b, pool_valid_out,
      output gnt_a, gnt_b, pool_clr_n, pool_valid_in,
      output pool_conv_out_1, pool_conv_out_2, pool_conv_out_3,
      output owner, busy, done_a, done_b, err_overrun
   );
endinterface

// File: rtl/pool_frame_arbiter.sv
// Frame-granular round-robin share of one maxpool between conv requesters A and B.
// Owner samples reach the pool 1 cycle later; no stall path, samples while ungranted are dropped.
module pool_frame_arbiter #(
   parameter int CONV_BIT    = 12,
   parameter int HALF_WIDTH  = 12,
   parameter int HALF_HEIGHT = 12,
   parameter int IN_CNT_BIT  = 10,
   parameter int OUT_CNT_BIT = 8
) (
   input logic              clk,
   input logic              rst_n,
   pool_frame_arbiter_if.slave bus
);
   localparam logic [IN_CNT_BIT-1:0]  IN_LAST   = IN_CNT_BIT'(4*HALF_WIDTH*HALF_HEIGHT - 1);
   localparam logic [OUT_CNT_BIT-1:0] OUT_TOTAL = OUT_CNT_BIT'(HALF_WIDTH*HALF_HEIGHT);
   localparam logic [OUT_CNT_BIT-1:0] OUT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

   state_t                 state;
   logic                   last_owner;
   logic [IN_CNT_BIT-1:0]  in_cnt;
   logic [OUT_CNT_BIT-1:0] out_cnt;
   logic                   pick_b;
   logic                   own_vld;
   logic [3*CONV_BIT-1:0]  own_dat;

   // B wins when it asks alone, or when both ask and A had the previous frame.
   assign pick_b  = bus.req_b && (!bus.req_a || !last_owner);
   assign own_vld = bus.owner ? bus.valid_b : bus.valid_a;
   assign own_dat = bus.owner ? bus.data_b  : bus.data_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         last_owner          <= 1'b1;
         in_cnt              <= '0;
         out_cnt             <= '0;
         bus.gnt_a           <= 1'b0;
         bus.gnt_b           <= 1'b0;
         bus.pool_clr_n      <= 1'b0;
         bus.pool_valid_in   <= 1'b0;
         bus.pool_conv_out_1 <= '0;
         bus.pool_conv_out_2 <= '0;
         bus.pool_conv_out_3 <= '0;
         bus.owner           <= 1'b0;
         bus.busy            <= 1'b0;
         bus.done_a          <= 1'b0;
         bus.done_b          <= 1'b0;
         bus.err_overrun     <= 1'b0;
      end else begin
         bus.done_a        <= 1'b0;
         bus.done_b        <= 1'b0;
         bus.pool_valid_in <= 1'b0;
         bus.pool_clr_n    <= 1'b1;

         if (bus.pool_valid_out) begin
            if (state == IDLE || state == CLEAR) begin
               bus.err_overrun <= 1'b1;
            end else begin
               if (out_cnt == OUT_TOTAL) bus.err_overrun <= 1'b1;
               if (out_cnt != OUT_MAX)   out_cnt <= out_cnt + 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (bus.req_a || bus.req_b) begin
                  bus.owner      <= pick_b;
                  in_cnt         <= '0;
                  out_cnt        <= '0;
                  bus.pool_clr_n <= 1'b0;
                  bus.busy       <= 1'b1;
                  state          <= CLEAR;
               end
            end
            CLEAR: begin
               bus.gnt_a <= !bus.owner;
               bus.gnt_b <= bus.owner;
               state     <= RUN;
            end
            RUN: begin
               if (own_vld) begin
                  bus.pool_valid_in   <= 1'b1;
                  bus.pool_conv_out_1 <= own_dat[CONV_BIT-1:0];
                  bus.pool_conv_out_2 <= own_dat[2*CONV_BIT-1:CONV_BIT];
                  bus.pool_conv_out_3 <= own_dat[3*CONV_BIT-1:2*CONV_BIT];
                  in_cnt              <= in_cnt + 1'b1;
                  if (in_cnt == IN_LAST) begin
                     bus.gnt_a <= 1'b0;
                     bus.gnt_b <= 1'b0;
                     state     <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (out_cnt == OUT_TOTAL) begin
                  bus.done_a <= !bus.owner;
                  bus.done_b <= bus.owner;
                  last_owner <= bus.owner;
                  bus.busy   <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pool_frame_arbiter.sv
// Randomized frame traffic for pool_frame_arbiter against a frame-level reference model;
// the shared pool is stood in for by a 4-inputs-per-output counter reset by pool_clr_n.
module tb_pool_frame_arbiter;
   localparam int CB        = 12;
   localparam int IN_TOTAL  = 576;
   localparam int OUT_TOTAL = 144;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   errors  = 0;
   bit   m_last;

   always #5 clk = ~clk;

   pool_frame_arbiter_if #(.CONV_BIT(CB)) bus ();

   pool_frame_arbiter #(
      .CONV_BIT(CB), .HALF_WIDTH(12), .HALF_HEIGHT(12), .IN_CNT_BIT(10), .OUT_CNT_BIT(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   // pool stand-in: one pooled result the cycle after every 4th accepted sample
   logic [1:0] stub_cnt;
   logic       stub_vld;
   logic       force_pvo;

   always_ff @(posedge clk or negedge bus.pool_clr_n) begin
      if (!bus.pool_clr_n) begin
         stub_cnt <= 2'd0;
         stub_vld <= 1'b0;
      end else begin
         stub_vld <= bus.pool_valid_in && (stub_cnt == 2'd3);
         if (bus.pool_valid_in) stub_cnt <= stub_cnt + 2'd1;
      end
   end

   assign bus.pool_valid_out = stub_vld | force_pvo;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctrl"}, 64'({bus.gnt_a, bus.gnt_b, bus.pool_clr_n, bus.pool_valid_in, bus.owner,
                               bus.busy, bus.done_a, bus.done_b, bus.err_overrun}), 64'd0);
      chk({tag, "_conv"}, 64'({bus.pool_conv_out_3, bus.pool_conv_out_2, bus.pool_conv_out_1}), 64'd0);
   endtask

   task automatic do_reset();
      bus.req_a = 1'b0; bus.req_b = 1'b0; bus.valid_a = 1'b0; bus.valid_b = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n  = 1'b1;
      m_last = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_release", 64'(bus.pool_clr_n), 64'd1);
      chk("idle_busy", 64'(bus.busy), 64'd0);
   endtask

   task automatic run_frame(input int duty, input bit noise, input int abort_at,
                            input bit drop_req, input bit exp_err);
      bit              who, got, acc, v, ov;
      int              n, pvo_cnt, clr_cnt, stray, done_cnt;
      logic [63:0]     r64;
      logic [3*CB-1:0] d, od;
      if (bus.req_a && !bus.req_b)      who = 1'b0;
      else if (!bus.req_a && bus.req_b) who = 1'b1;
      else                              who = !m_last;
      got = 1'b0; clr_cnt = 0; stray = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         #1;
         if (bus.busy && !bus.pool_clr_n) clr_cnt++;
         if (bus.done_a || bus.done_b) stray++;
         if (bus.gnt_a || bus.gnt_b) got = 1'b1;
      end
      chk("grant_seen", 64'(got), 64'd1);
      chk("grant_owner", 64'(who ? bus.gnt_b : bus.gnt_a), 64'd1);
      chk("grant_other", 64'(who ? bus.gnt_a : bus.gnt_b), 64'd0);
      chk("owner_at_grant", 64'(bus.owner), 64'(who));
      chk("clear_cycles", 64'(clr_cnt), 64'd1);
      chk("done_width", 64'(stray), 64'd0);
      if (drop_req) begin
         bus.req_a = 1'b0;
         bus.req_b = 1'b0;
      end
      n = 0; pvo_cnt = 0; done_cnt = 0;
      for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
         r64 = {$urandom(), $urandom()};
         d   = r64[3*CB-1:0];
         r64 = {$urandom(), $urandom()};
         od  = r64[3*CB-1:0];
         v   = ($urandom_range(99, 0) < duty);
         ov  = 1'($urandom_range(1, 0));
         if (noise) begin
            ov = 1'b1;
            od = {3{12'h7FF}};
         end
         if (who) begin
            bus.valid_b = v;  bus.data_b = d;  bus.valid_a = ov; bus.data_a = od;
         end else begin
            bus.valid_a = v;  bus.data_a = d;  bus.valid_b = ov; bus.data_b = od;
         end
         acc = v && (n < IN_TOTAL);
         @(posedge clk);
         #1;
         if (acc) n++;
         chk("pool_valid_in", 64'(bus.pool_valid_in), 64'(acc));
         if (acc)
            chk("pool_dat", 64'({bus.pool_conv_out_3, bus.pool_conv_out_2, bus.pool_conv_out_1}), 64'(d));
         chk("gnt_run", 64'(who ? bus.gnt_b : bus.gnt_a), 64'(n < IN_TOTAL));
         chk("gnt_nonowner", 64'(who ? bus.gnt_a : bus.gnt_b), 64'd0);
         chk("done_nonowner", 64'(who ? bus.done_a : bus.done_b), 64'd0);
         pvo_cnt += int'(bus.pool_valid_out);
         if (who ? bus.done_b : bus.done_a) done_cnt++;
         if (abort_at >= 0 && n == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk_all_zero("midframe_reset");
            bus.valid_a = 1'b0; bus.valid_b = 1'b0; bus.req_a = 1'b0; bus.req_b = 1'b0;
            @(posedge clk);
            #1;
            chk("reset_no_done", 64'({bus.done_a, bus.done_b}), 64'd0);
            rst_n  = 1'b1;
            m_last = 1'b1;
            return;
         end
      end
      bus.valid_a = 1'b0;
      bus.valid_b = 1'b0;
      chk("frame_done", 64'(done_cnt), 64'd1);
      chk("samples_in", 64'(n), 64'(IN_TOTAL));
      chk("pooled_out", 64'(pvo_cnt), 64'(OUT_TOTAL));
      chk("busy_at_done", 64'(bus.busy), 64'd0);
      chk("owner_at_done", 64'(bus.owner), 64'(who));
      chk("err_overrun", 64'(bus.err_overrun), 64'(exp_err));
      m_last = who;
   endtask

   initial begin
      bus.req_a = 1'b0; bus.req_b = 1'b0; bus.valid_a = 1'b0; bus.valid_b = 1'b0;
      bus.data_a = '0; bus.data_b = '0;
      force_pvo = 1'b0;
      do_reset();

      // single requester, back-to-back samples
      bus.req_a = 1'b1;
      run_frame(100, 1'b0, -1, 1'b1, 1'b0);

      // both held from reset: A, B, A, B
      do_reset();
      bus.req_a = 1'b1; bus.req_b = 1'b1;
      repeat (4) run_frame(85, 1'b0, -1, 1'b0, 1'b0);
      bus.req_a = 1'b0; bus.req_b = 1'b0;

      // sparse owner valids
      bus.req_a = 1'b1;
      run_frame(50, 1'b0, -1, 1'b1, 1'b0);

      // non-owner saturating noise must never reach the pool
      bus.req_a = 1'b1;
      run_frame(70, 1'b1, -1, 1'b1, 1'b0);

      // reset partway through an A frame, then a B frame
      bus.req_a = 1'b1;
      run_frame(90, 1'b0, 300, 1'b1, 1'b0);
      bus.req_b = 1'b1;
      run_frame(100, 1'b0, -1, 1'b1, 1'b0);

      // stray pooled result while idle makes the error sticky
      repeat (2) @(posedge clk);
      #1;
      chk("err_before_force", 64'(bus.err_overrun), 64'd0);
      force_pvo = 1'b1;
      @(posedge clk);
      #1;
      force_pvo = 1'b0;
      chk("err_after_force", 64'(bus.err_overrun), 64'd1);
      chk("busy_after_force", 64'(bus.busy), 64'd0);
      @(posedge clk);
      #1;
      chk("err_sticky", 64'(bus.err_overrun), 64'd1);
      bus.req_a = 1'b1; bus.req_b = 1'b1;
      run_frame(100, 1'b0, -1, 1'b1, 1'b1);
      do_reset();
      chk("err_cleared", 64'(bus.err_overrun), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
